// File: rtl/rotary_pkg.sv
// ---------------------------------------------------------------------------
// rotary_pkg
// Shared definitions for the rotary steering front end and the drive-pattern
// stage downstream of it:
//   - 3-bit steering codes (CASE values)
//   - position zone thresholds (upper bound of each zone, inclusive)
//   - decoder FSM state type
//   - case_of(): maps an 8-bit position to its steering code
// ---------------------------------------------------------------------------
package rotary_pkg;

    // Steering codes. The MSB set means clockwise of centre.
    localparam logic [2:0] CASE_CENTER = 3'b000;
    localparam logic [2:0] CASE_CW1    = 3'b101;
    localparam logic [2:0] CASE_CW2    = 3'b110;
    localparam logic [2:0] CASE_CW3    = 3'b111;
    localparam logic [2:0] CASE_CCW1   = 3'b001;
    localparam logic [2:0] CASE_CCW2   = 3'b010;
    localparam logic [2:0] CASE_CCW3   = 3'b011;

    // Inclusive upper bound of each position zone, in ascending order.
    localparam logic [7:0] ZONE_CENTER_HI = 8'd2;
    localparam logic [7:0] ZONE_CW1_HI    = 8'd6;
    localparam logic [7:0] ZONE_CW2_HI    = 8'd10;
    localparam logic [7:0] ZONE_CW3_HI    = 8'd126;
    localparam logic [7:0] ZONE_CCW3_HI   = 8'd245;
    localparam logic [7:0] ZONE_CCW2_HI   = 8'd249;
    localparam logic [7:0] ZONE_CCW1_HI   = 8'd253;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Positions above ZONE_CCW1_HI (254, 255) sit just CCW of zero and are
    // treated as centre, so the centre zone straddles the wrap point.
    function automatic logic [2:0] case_of(input logic [7:0] value);
        if      (value <= ZONE_CENTER_HI) case_of = CASE_CENTER;
        else if (value <= ZONE_CW1_HI)    case_of = CASE_CW1;
        else if (value <= ZONE_CW2_HI)    case_of = CASE_CW2;
        else if (value <= ZONE_CW3_HI)    case_of = CASE_CW3;
        else if (value <= ZONE_CCW3_HI)   case_of = CASE_CCW3;
        else if (value <= ZONE_CCW2_HI)   case_of = CASE_CCW2;
        else if (value <= ZONE_CCW1_HI)   case_of = CASE_CCW1;
        else                              case_of = CASE_CENTER;
    endfunction

endpackage

// File: rtl/rotary_debounce.sv
// ---------------------------------------------------------------------------
// rotary_debounce
// Two-flop synchroniser followed by a stable-count filter for one encoder
// phase. The filtered value only follows the synchronised input after it
// has disagreed with the filtered value for DEB_CYCLES consecutive cycles.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   raw       asynchronous encoder phase
//   load      force filtered <= synced immediately (used during start-up)
//   synced    synchroniser output
//   filtered  debounced phase
// ---------------------------------------------------------------------------
module rotary_debounce #(
    parameter int DEB_CYCLES = 30000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic load,
    output logic synced,
    output logic filtered
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             meta;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser chain
    // depends on this).
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b0;
            synced   <= 1'b0;
            filtered <= 1'b0;
            cnt      <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            if (load) begin
                filtered <= synced;
                cnt      <= '0;
            end else if (synced == filtered) begin
                // Any return to the filtered value restarts the count, so
                // glitches shorter than DEB_CYCLES leave no trace.
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                // This is the DEB_CYCLES-th consecutive differing cycle.
                filtered <= synced;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotary_decoder.sv
// ---------------------------------------------------------------------------
// rotary_decoder
// Debounces the quadrature phases of the steering encoder, decodes detents
// into a wrap-around 8-bit position and registers the matching steering code.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rota/rotb  raw encoder phases (asynchronous)
//   center     zero the position on the next edge (wins over a step)
//   pos        current position, modulo 256
//   case_code  steering code of pos
//   step       one-cycle pulse when pos moves by a detent
//   dir        direction of the last step, 1 = CW (+1), 0 = CCW (-1)
//   err        one-cycle pulse when both filtered phases change together
// ---------------------------------------------------------------------------
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int DEB_CYCLES = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rota,
    input  logic       rotb,
    input  logic       center,
    output logic [7:0] pos,
    output logic [2:0] case_code,
    output logic       step,
    output logic       dir,
    output logic       err
);

    state_t     state;
    logic [1:0] init_cnt;
    logic       load;
    logic       a_s, b_s, a_f, b_f;
    logic [1:0] prev_ab;
    logic [1:0] changed;
    logic       step_req;
    logic       err_req;
    logic       cw_req;
    logic [7:0] pos_next;

    // Two settle cycles in INIT, then a direct load on the third.
    assign load = (state == ST_INIT) && (init_cnt == 2'd2);

    rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk      (clk),
        .rst      (rst),
        .raw      (rota),
        .load     (load),
        .synced   (a_s),
        .filtered (a_f)
    );

    rotary_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk      (clk),
        .rst      (rst),
        .raw      (rotb),
        .load     (load),
        .synced   (b_s),
        .filtered (b_f)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        changed  = {a_f, b_f} ^ prev_ab;
        step_req = 1'b0;
        err_req  = 1'b0;
        cw_req   = ~b_f;
        if (state == ST_RUN) begin
            // Only an A rising edge with B steady counts as a detent.
            step_req = (changed == 2'b10) && a_f;
            err_req  = (changed == 2'b11);
        end
        if (center)
            pos_next = 8'd0;
        else if (step_req)
            pos_next = cw_req ? pos + 8'd1 : pos - 8'd1;
        else
            pos_next = pos;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= 2'd0;
            prev_ab   <= 2'b00;
            pos       <= 8'd0;
            case_code <= CASE_CENTER;
            step      <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // Track the synchroniser so that prev_ab equals the
                    // freshly loaded filtered value: no phantom step.
                    prev_ab <= {a_s, b_s};
                    if (load)
                        state <= ST_RUN;
                    else
                        init_cnt <= init_cnt + 2'd1;
                end
                ST_RUN: begin
                    prev_ab <= {a_f, b_f};
                end
            endcase

            pos       <= pos_next;
            case_code <= case_of(pos_next);
            step      <= step_req & ~center;
            if (step_req && !center)
                dir <= cw_req;
            err       <= err_req;
        end
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// ---------------------------------------------------------------------------
// tb_rotary_decoder
// Directed bench for rotary_decoder with DEB_CYCLES = 4. Inputs change 1 ns
// after a rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rotary_decoder;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rota;
    logic       rotb;
    logic       center;
    logic [7:0] pos;
    logic [2:0] case_code;
    logic       step;
    logic       dir;
    logic       err;

    int errors = 0;
    int checks = 0;

    // Event counters updated on every falling edge.
    int steps      = 0;
    int cw_steps   = 0;
    int zero_hits  = 0;
    int err_pulses = 0;

    int base_steps, base_cw, base_zero, base_err;

    rotary_decoder #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rota      (rota),
        .rotb      (rotb),
        .center    (center),
        .pos       (pos),
        .case_code (case_code),
        .step      (step),
        .dir       (dir),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) begin
            steps++;
            if (dir) cw_steps++;
            if (pos == 8'd0) zero_hits++;
        end
        if (err) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic a, input logic b, input int hold);
        rota = a;
        rotb = b;
        cyc(hold);
    endtask

    task automatic cw_detent;
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
    endtask

    task automatic ccw_detent;
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b0, 1'b0, 8);
    endtask

    task automatic snap;
        base_steps = steps;
        base_cw    = cw_steps;
        base_zero  = zero_hits;
        base_err   = err_pulses;
    endtask

    initial begin
        rst    = 1'b1;
        rota   = 1'b1;
        rotb   = 1'b1;
        center = 1'b0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pos",  pos,       8'd0);
        check("reset_case", case_code, 3'b000);
        check("reset_step", step,      1'b0);
        check("reset_dir",  dir,       1'b0);
        check("reset_err",  err,       1'b0);

        // Phases held high through start-up: nothing may happen.
        cyc(50);
        check("idle11_steps", steps,      0);
        check("idle11_errs",  err_pulses, 0);
        check("idle11_pos",   pos,        8'd0);
        check("idle11_case",  case_code,  3'b000);

        // Walk 11 -> 01 -> 00 with single-bit changes: no steps.
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        check("to00_steps", steps, 0);

        // First CW detent with exact latency: A rise visible on STEP
        // DEB+3 edges after the change.
        snap();
        rota = 1'b1;
        cyc(DEB + 2);
        @(negedge clk);
        check("lat_step_early", step, 1'b0);
        cyc(1);
        @(negedge clk);
        check("lat_step",      step,      1'b1);
        check("lat_dir",       dir,       1'b1);
        check("lat_pos",       pos,       8'd1);
        check("lat_case",      case_code, 3'b000);
        cyc(1);
        @(negedge clk);
        check("lat_step_width", step, 1'b0);
        cyc(1);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        cw_detent();
        cw_detent();
        check("cw3_steps", steps - base_steps, 3);
        check("cw3_cw",    cw_steps - base_cw, 3);
        check("cw3_pos",   pos,       8'd3);
        check("cw3_case",  case_code, 3'b101);

        // Centre, then CCW across zero.
        center = 1'b1;
        cyc(1);
        center = 1'b0;
        check("center_pos",  pos,       8'd0);
        check("center_case", case_code, 3'b000);
        ccw_detent();
        check("ccw1_pos",  pos,       8'd255);
        check("ccw1_case", case_code, 3'b000);
        check("ccw1_dir",  dir,       1'b0);
        ccw_detent();
        ccw_detent();
        check("ccw3_pos",  pos,       8'd253);
        check("ccw3_case", case_code, 3'b001);

        // A full revolution of CW detents returns to 253 via one 255->0 wrap.
        snap();
        repeat (256) cw_detent();
        check("rev_steps", steps - base_steps,    256);
        check("rev_cw",    cw_steps - base_cw,    256);
        check("rev_wrap",  zero_hits - base_zero, 1);
        check("rev_pos",   pos,       8'd253);
        check("rev_case",  case_code, 3'b001);

        // Bounce on A: 3-cycle highs separated by 2-cycle lows.
        snap();
        repeat (4) begin
            rota = 1'b1;
            cyc(3);
            rota = 1'b0;
            cyc(2);
        end
        cyc(20);
        check("bounce_steps", steps - base_steps, 0);
        check("bounce_pos",   pos,                8'd253);

        // Reach 12, then CENTER on the very edge a CW step decodes.
        repeat (15) cw_detent();
        check("at12_pos",  pos,       8'd12);
        check("at12_case", case_code, 3'b111);
        snap();
        rota = 1'b1;
        cyc(DEB + 2);
        center = 1'b1;
        cyc(1);
        center = 1'b0;
        @(negedge clk);
        check("ctrstep_pos",  pos,       8'd0);
        check("ctrstep_case", case_code, 3'b000);
        check("ctrstep_step", step,      1'b0);
        check("ctrstep_dir",  dir,       1'b1);
        cyc(1);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        check("ctrstep_nsteps", steps - base_steps, 0);
        check("ctrstep_hold",   pos,                8'd0);

        // Both phases toggle together: a single ERR pulse, POS held.
        snap();
        rota = 1'b1;
        rotb = 1'b1;
        cyc(DEB + 2);
        @(negedge clk);
        check("err_early", err, 1'b0);
        cyc(1);
        @(negedge clk);
        check("err_pulse", err,  1'b1);
        check("err_step",  step, 1'b0);
        check("err_pos",   pos,  8'd0);
        cyc(1);
        @(negedge clk);
        check("err_width", err, 1'b0);
        cyc(10);
        check("err_count",  err_pulses - base_err, 1);
        check("err_nsteps", steps - base_steps,    0);

        // Back to 00 and one CW detent so outputs are non-zero before RST.
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        cw_detent();
        check("prerst_pos", pos, 8'd1);
        check("prerst_dir", dir, 1'b1);

        // RST in the middle of a debounce count.
        snap();
        rota = 1'b1;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_pos",  pos,       8'd0);
        check("midrst_case", case_code, 3'b000);
        check("midrst_step", step,      1'b0);
        check("midrst_dir",  dir,       1'b0);
        check("midrst_err",  err,       1'b0);
        cyc(30);
        check("midrst_nsteps", steps - base_steps,    0);
        check("midrst_nerrs",  err_pulses - base_err, 0);
        check("midrst_hold",   pos,                   8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
